// File: rtl/perf_counter_bank.sv
// Bank of NUM_EVT event counters with wrap/saturate, sticky overflow, atomic snapshot,
// and a registered hex display word that shows one channel or auto-scans all of them.
module perf_counter_bank #(
  parameter int NUM_EVT  = 4,
  parameter int CNT_W    = 11,
  parameter int SEL_W    = 3,
  parameter int SCAN_DIV = 50
) (
  input  logic                     external_clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     sat_mode,
  input  logic                     snap,
  input  logic                     show_snap,
  input  logic [NUM_EVT-1:0]       evt_inc,
  input  logic [SEL_W-1:0]         sel,
  output logic [NUM_EVT*CNT_W-1:0] cnt_flat,
  output logic [NUM_EVT-1:0]       ovf,
  output logic [31:0]              hex
);

  localparam logic [CNT_W-1:0] MAXV     = '1;
  localparam logic [SEL_W-1:0] SCAN_SEL = '1;
  localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_EVT - 1);

  logic [CNT_W-1:0] r_cnt    [NUM_EVT];
  logic [CNT_W-1:0] r_shadow [NUM_EVT];
  logic [NUM_EVT-1:0] r_ovf;
  logic [SEL_W-1:0] r_scan_idx;
  logic [DIV_W-1:0] r_scan_div;
  logic [31:0]      r_hex;

  logic             w_scan;
  logic             w_chan_vld;
  logic [SEL_W-1:0] w_chan;
  logic [31:0]      w_hex_nxt;

  assign w_scan = (sel == SCAN_SEL);

  // Shadow captures pre-edge values, so a same-cycle clear or increment never leaks in.
  always_ff @(posedge external_clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_EVT; k++) begin
        r_cnt[k]    <= '0;
        r_shadow[k] <= '0;
      end
      r_ovf <= '0;
    end else begin
      if (snap) begin
        for (int k = 0; k < NUM_EVT; k++) r_shadow[k] <= r_cnt[k];
      end
      if (clear) begin
        for (int k = 0; k < NUM_EVT; k++) r_cnt[k] <= '0;
        r_ovf <= '0;
      end else if (enable) begin
        for (int k = 0; k < NUM_EVT; k++) begin
          if (evt_inc[k]) begin
            if (r_cnt[k] == MAXV) begin
              r_ovf[k] <= 1'b1;
              if (!sat_mode) r_cnt[k] <= '0;
            end else begin
              r_cnt[k] <= r_cnt[k] + CNT_W'(1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge external_clk or negedge reset) begin
    if (!reset) begin
      r_scan_idx <= '0;
      r_scan_div <= '0;
    end else if (!w_scan) begin
      r_scan_idx <= '0;
      r_scan_div <= '0;
    end else if (r_scan_div == DIV_LAST) begin
      r_scan_div <= '0;
      r_scan_idx <= (r_scan_idx == IDX_LAST) ? '0 : r_scan_idx + SEL_W'(1);
    end else begin
      r_scan_div <= r_scan_div + DIV_W'(1);
    end
  end

  always_comb begin
    w_hex_nxt  = '0;
    w_chan     = '0;
    w_chan_vld = 1'b0;
    if (sel < SEL_W'(NUM_EVT)) begin
      w_chan     = sel;
      w_chan_vld = 1'b1;
    end else if (w_scan) begin
      w_chan     = r_scan_idx;
      w_chan_vld = 1'b1;
    end
    if (w_chan_vld) begin
      for (int k = 0; k < NUM_EVT; k++) begin
        if (w_chan == SEL_W'(k)) begin
          w_hex_nxt[31:28]      = 4'(w_chan);
          w_hex_nxt[27]         = show_snap;
          w_hex_nxt[26]         = r_ovf[k];
          w_hex_nxt[CNT_W-1:0]  = show_snap ? r_shadow[k] : r_cnt[k];
        end
      end
    end
  end

  always_ff @(posedge external_clk or negedge reset) begin
    if (!reset) r_hex <= '0;
    else        r_hex <= w_hex_nxt;
  end

  for (genvar g = 0; g < NUM_EVT; g++) begin : g_flat
    assign cnt_flat[g*CNT_W +: CNT_W] = r_cnt[g];
  end

  assign ovf = r_ovf;
  assign hex = r_hex;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: an arithmetic reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_perf_counter_bank;
  localparam int N    = 4;
  localparam int CW   = 11;
  localparam int SW   = 3;
  localparam int SD   = 4;
  localparam int MAXV = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0, clear = 1'b0, sat_mode = 1'b0, snap = 1'b0, show_snap = 1'b0;
  logic [N-1:0]      evt_inc = '0;
  logic [SW-1:0]     sel = '0;
  logic [N*CW-1:0]   cnt_flat;
  logic [N-1:0]      ovf;
  logic [31:0]       hex;

  int checks = 0;
  int errors = 0;

  perf_counter_bank #(.NUM_EVT(N), .CNT_W(CW), .SEL_W(SW), .SCAN_DIV(SD)) dut (
    .external_clk(clk), .reset(rst_n), .enable(enable), .clear(clear),
    .sat_mode(sat_mode), .snap(snap), .show_snap(show_snap), .evt_inc(evt_inc),
    .sel(sel), .cnt_flat(cnt_flat), .ovf(ovf), .hex(hex)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int k);
    return 32'(cnt_flat[k*CW +: CW]);
  endfunction

  // Reference model: integer counts, a running count of consecutive scan cycles.
  int          m_cnt [N];
  int          m_sh  [N];
  bit          m_ovf [N];
  int          m_scan_t;
  logic [31:0] m_hex;
  int          mc;
  bit          mshow;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        m_cnt[k] = 0;
        m_sh[k]  = 0;
        m_ovf[k] = 0;
      end
      m_scan_t = 0;
      m_hex    = '0;
    end else begin
      mshow = 1;
      mc    = 0;
      if (int'(sel) < N) begin
        mc = int'(sel);
        m_scan_t = 0;
      end else if (int'(sel) == (1 << SW) - 1) begin
        mc = (m_scan_t / SD) % N;
        m_scan_t++;
      end else begin
        mshow = 0;
        m_scan_t = 0;
      end
      m_hex = mshow ? 32'((mc << 28) | (int'(show_snap) << 27) | (int'(m_ovf[mc]) << 26)
                          | (show_snap ? m_sh[mc] : m_cnt[mc])) : 32'h0;
      if (snap) for (int k = 0; k < N; k++) m_sh[k] = m_cnt[k];
      if (clear) begin
        for (int k = 0; k < N; k++) begin
          m_cnt[k] = 0;
          m_ovf[k] = 0;
        end
      end else if (enable) begin
        for (int k = 0; k < N; k++) begin
          if (evt_inc[k]) begin
            if (m_cnt[k] == MAXV) m_ovf[k] = 1;
            m_cnt[k] = sat_mode ? ((m_cnt[k] + 1 > MAXV) ? MAXV : m_cnt[k] + 1)
                                : (m_cnt[k] + 1) % (MAXV + 1);
          end
        end
      end
    end
  end

  function automatic logic [31:0] m_ovf_word();
    logic [31:0] w = '0;
    for (int k = 0; k < N; k++) w[k] = m_ovf[k];
    return w;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < N; k++) chk($sformatf("model_cnt%0d", k), cnt_of(k), 32'(m_cnt[k]));
      chk("model_ovf", 32'(ovf), m_ovf_word());
      chk("model_hex", hex, m_hex);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cycles(2);
    chk("rst_cnt", 32'(|cnt_flat), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_hex", hex, 32'h0);
    rst_n = 1'b1;

    // Basic counting on all channels
    enable = 1'b1; evt_inc = 4'b1111; sel = 3'd2;
    cycles(10);
    for (int k = 0; k < N; k++) chk($sformatf("t1_cnt%0d", k), cnt_of(k), 32'd10);
    chk("t1_ovf", 32'(ovf), 32'h0);
    evt_inc = '0;
    cycles(1);
    chk("t1_hex", hex, 32'h2000000A);

    // Wrap mode
    clear = 1'b1; cycles(1); clear = 1'b0;
    evt_inc = 4'b0001;
    cycles(2047);
    chk("t2_cnt0_max", cnt_of(0), 32'd2047);
    chk("t2_ovf_pre", 32'(ovf), 32'h0);
    cycles(1);
    chk("t2_cnt0_wrap", cnt_of(0), 32'd0);
    chk("t2_ovf_set", 32'(ovf), 32'h1);
    cycles(5);
    chk("t2_cnt0_5", cnt_of(0), 32'd5);
    chk("t2_ovf_sticky", 32'(ovf), 32'h1);
    evt_inc = '0; clear = 1'b1; cycles(1); clear = 1'b0;
    chk("t2_cnt0_clr", cnt_of(0), 32'd0);
    chk("t2_ovf_clr", 32'(ovf), 32'h0);

    // Saturate mode
    sat_mode = 1'b1; evt_inc = 4'b0010;
    cycles(2050);
    chk("t3_cnt1_sat", cnt_of(1), 32'd2047);
    chk("t3_ovf", 32'(ovf), 32'h2);
    evt_inc = '0; sel = 3'd1; show_snap = 1'b0;
    cycles(1);
    chk("t3_hex", hex, 32'h140007FF);

    // Snapshot together with clear
    sat_mode = 1'b0; clear = 1'b1; cycles(1); clear = 1'b0;
    evt_inc = 4'b1000;
    cycles(7);
    chk("t4_cnt3_pre", cnt_of(3), 32'd7);
    snap = 1'b1; clear = 1'b1;
    cycles(1);
    snap = 1'b0; clear = 1'b0; evt_inc = '0;
    chk("t4_cnt3_clr", cnt_of(3), 32'd0);
    sel = 3'd3; show_snap = 1'b1;
    cycles(1);
    chk("t4_hex_shadow", hex, 32'h38000007);

    // Scan mode
    show_snap = 1'b0; sel = 3'd7;
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      chk($sformatf("t5_scan%0d", i), 32'(hex[31:28]), 32'((i / 4) % 4));
    end
    sel = 3'd0; cycles(1); sel = 3'd7;
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      chk($sformatf("t5_rescan%0d", i), 32'(hex[31:28]), 32'((i / 4) % 4));
    end
    sel = 3'd5;
    cycles(1);
    chk("t5_hex_blank", hex, 32'h0);

    // Asynchronous reset mid-count
    sel = 3'd0; evt_inc = 4'b1111;
    cycles(3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_cnt_async", 32'(|cnt_flat), 32'h0);
    chk("t6_ovf_async", 32'(ovf), 32'h0);
    chk("t6_hex_async", hex, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(3);
    for (int k = 0; k < N; k++) chk($sformatf("t6_cnt%0d", k), cnt_of(k), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
